// File: rtl/display_scan_mux.sv
// Time-multiplexed 7-segment scan driver: per-frame image snapshot, one digit per slot,
// with dead-time, PWM brightness, leading-zero blanking and enable control. Outputs are registered.
module display_scan_mux #(
  parameter int DIGITS   = 4,
  parameter int DIV      = 50000,
  parameter int DEAD     = 2,
  parameter int BRIGHT_W = 4
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_en,
  input  logic [4*DIGITS-1:0]   i_in,
  input  logic [DIGITS-1:0]     i_dp_in,
  input  logic                  i_blank_lz,
  input  logic [BRIGHT_W-1:0]   i_bright,
  output logic [3:0]            o_out,
  output logic                  o_dp,
  output logic [DIGITS-1:0]     o_bit,
  output logic                  o_frame_start
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(DIV - 1);
  localparam logic [DW-1:0] D_LAST = DW'(DIGITS - 1);

  logic [PW-1:0]       r_p;
  logic [DW-1:0]       r_d;
  logic [BRIGHT_W-1:0] r_w;
  logic [4*DIGITS-1:0] r_img;
  logic [DIGITS-1:0]   r_img_dp;
  logic [3:0]          r_out;
  logic                r_dp;
  logic                r_lz;
  logic [DIGITS-1:0]   r_bit;
  logic                r_fs;

  logic                w_slot_start;
  logic                w_capture;
  logic [4*DIGITS-1:0] w_src;
  logic [DIGITS-1:0]   w_src_dp;
  logic [3:0]          w_nib;
  logic                w_dp_sel;
  logic                w_zero_prefix;
  logic                w_lz_new;
  logic                w_lz_cur;
  logic                w_duty;
  logic                w_past_dead;
  logic                w_lit;
  logic [DIGITS-1:0]   w_anode;

  generate
    if (DEAD == 0) begin : g_no_dead
      assign w_past_dead = 1'b1;
    end else begin : g_dead
      assign w_past_dead = (r_p >= PW'(DEAD));
    end
  endgenerate

  // Digit 0 reads the word being captured this edge so the whole frame comes from one snapshot.
  always_comb begin
    w_slot_start  = (r_p == '0);
    w_capture     = w_slot_start && (r_d == '0);
    w_src         = w_capture ? i_in : r_img;
    w_src_dp      = w_capture ? i_dp_in : r_img_dp;
    w_nib         = 4'h0;
    w_dp_sel      = 1'b0;
    w_zero_prefix = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (int'(r_d) == k) begin
        w_nib    = w_src[4*(DIGITS-1-k) +: 4];
        w_dp_sel = w_src_dp[DIGITS-1-k];
      end
      if ((k <= int'(r_d)) && (w_src[4*(DIGITS-1-k) +: 4] != 4'h0)) begin
        w_zero_prefix = 1'b0;
      end
    end
    w_lz_new = i_blank_lz && w_zero_prefix && (r_d != D_LAST);
    // The registered mask is only valid after the slot-start edge; use the fresh value on p=0.
    w_lz_cur = w_slot_start ? w_lz_new : r_lz;
    w_duty   = (&i_bright) || (r_w < i_bright);
    w_lit    = w_past_dead && w_duty && !w_lz_cur;
    w_anode  = '1;
    for (int k = 0; k < DIGITS; k++) begin
      if (w_lit && (int'(r_d) == k)) begin
        w_anode[DIGITS-1-k] = 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_p      <= '0;
      r_d      <= '0;
      r_w      <= '0;
      r_img    <= '0;
      r_img_dp <= '0;
      r_out    <= 4'h0;
      r_dp     <= 1'b0;
      r_lz     <= 1'b0;
      r_bit    <= '1;
      r_fs     <= 1'b0;
    end else if (!i_en) begin
      r_p   <= '0;
      r_d   <= '0;
      r_w   <= '0;
      r_bit <= '1;
      r_fs  <= 1'b0;
    end else begin
      if (r_p == P_LAST) begin
        r_p <= '0;
        r_d <= (r_d == D_LAST) ? '0 : r_d + DW'(1);
      end else begin
        r_p <= r_p + PW'(1);
      end
      r_w   <= r_w + BRIGHT_W'(1);
      r_bit <= w_anode;
      r_fs  <= w_capture;
      if (w_capture) begin
        r_img    <= i_in;
        r_img_dp <= i_dp_in;
      end
      if (w_slot_start) begin
        r_out <= w_nib;
        r_dp  <= w_dp_sel;
        r_lz  <= w_lz_new;
      end
    end
  end

  assign o_out         = r_out;
  assign o_dp          = r_dp;
  assign o_bit         = r_bit;
  assign o_frame_start = r_fs;

endmodule
